// File: rtl/rd_control_if.sv
// Bus bundle between the top-level controller and the read sequencer.
// The controller side (master) requests waves; the sequencer side (slave) drives
// the per-bank read pattern and reports status.
interface rd_control_if #(
   parameter int unsigned width_height = 16
);
   localparam int unsigned data_width = 8 * width_height;

   logic                    start;
   logic [7:0]              base_addr;
   logic [width_height-1:0] rd_en;
   logic [data_width-1:0]   rd_addr;
   logic                    busy;
   logic                    done;

   modport master (
      output start,
      output base_addr,
      input  rd_en,
      input  rd_addr,
      input  busy,
      input  done
   );

   modport slave (
      input  start,
      input  base_addr,
      output rd_en,
      output rd_addr,
      output busy,
      output done
   );
endinterface

// File: rtl/rd_control.sv
// Read-side sequencer for the per-row memory banks. A start request launches one
// diagonally skewed wave: bank i reads width_height consecutive words from a common
// base, beginning i cycles after bank 0. All outputs are registered.
module rd_control #(
   parameter int unsigned width_height = 16
) (
   input logic         clk,
   input logic         reset,
   rd_control_if.slave bus
);
   localparam int unsigned data_width = 8 * width_height;
   localparam int unsigned CntW       = $clog2(2 * width_height);
   localparam logic [CntW-1:0] LastT  = CntW'(2 * width_height - 2);

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e                  state_q, state_d;
   logic [CntW-1:0]         t_q, t_d;
   logic [7:0]              base_q, base_d;
   logic [width_height-1:0] rd_en_q, rd_en_d;
   logic [data_width-1:0]   rd_addr_q, rd_addr_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic [31:0]             t_n;

   // Next-state: accept a wave only from idle, step the cycle counter while running.
   always_comb begin
      state_d = state_q;
      t_d     = t_q;
      base_d  = base_q;
      done_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               state_d = StRun;
               t_d     = '0;
               base_d  = bus.base_addr;
            end
         end
         StRun: begin
            if (t_q == LastT) begin
               state_d = StIdle;
               t_d     = '0;
               done_d  = 1'b1;
            end else begin
               t_d = t_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Output pattern for the upcoming cycle, derived from next state so outputs can be flopped.
   always_comb begin
      busy_d    = (state_d == StRun);
      rd_en_d   = '0;
      rd_addr_d = '0;
      t_n       = 32'(t_d);
      for (int unsigned i = 0; i < width_height; i++) begin
         // Bank i is live for cycles i .. i+width_height-1; disabled banks present address 0.
         if (busy_d && (t_n >= i) && (t_n <= i + width_height - 1)) begin
            rd_en_d[i]          = 1'b1;
            rd_addr_d[8*i +: 8] = base_d + 8'(t_n - i);
         end
      end
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= StIdle;
         t_q       <= '0;
         base_q    <= '0;
         rd_en_q   <= '0;
         rd_addr_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         t_q       <= t_d;
         base_q    <= base_d;
         rd_en_q   <= rd_en_d;
         rd_addr_q <= rd_addr_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign bus.rd_en   = rd_en_q;
   assign bus.rd_addr = rd_addr_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
endmodule

// File: tb/tb_rd_control.sv
// Bench for rd_control: a 4-bank and a 16-bank instance run side by side, each
// tracked every cycle by a wave-level reference model, plus directed sequences.
module tb_rd_control;
   logic clk;
   logic rst4_n;
   logic rst16_n;
   int   n_checks;
   int   n_fail;

   rd_control_if #(.width_height(4))  if4 ();
   rd_control_if #(.width_height(16)) if16 ();

   rd_control #(.width_height(4)) u_dut4 (
      .clk   (clk),
      .reset (rst4_n),
      .bus   (if4)
   );

   rd_control #(.width_height(16)) u_dut16 (
      .clk   (clk),
      .reset (rst16_n),
      .bus   (if16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: is a wave active, how many cycles into it, its base, done pending.
   typedef struct packed {
      logic       act;
      logic [7:0] t;
      logic [7:0] base;
      logic       done;
   } mst_t;

   mst_t m4;
   mst_t m16;

   function automatic mst_t m_next(mst_t s, int w, logic rst_n, logic start, logic [7:0] b);
      mst_t n;
      n = s;
      if (!rst_n) begin
         n = '0;
      end else if (s.act) begin
         if (int'(s.t) == 2 * w - 2) begin
            n.act  = 1'b0;
            n.t    = '0;
            n.done = 1'b1;
         end else begin
            n.t = s.t + 8'd1;
         end
      end else begin
         n.done = 1'b0;
         if (start) begin
            n.act  = 1'b1;
            n.t    = '0;
            n.base = b;
         end
      end
      return n;
   endfunction

   always @(posedge clk or negedge rst4_n) m4 <= m_next(m4, 4, rst4_n, if4.start, if4.base_addr);
   always @(posedge clk or negedge rst16_n) begin
      m16 <= m_next(m16, 16, rst16_n, if16.start, if16.base_addr);
   end

   function automatic logic [127:0] e_en(mst_t s, int w);
      logic [127:0] r;
      r = '0;
      for (int i = 0; i < w; i++) begin
         if (s.act && int'(s.t) >= i && int'(s.t) - i < w) r[i] = 1'b1;
      end
      return r;
   endfunction

   function automatic logic [127:0] e_addr(mst_t s, int w);
      logic [127:0] r;
      int           off;
      r = '0;
      for (int i = 0; i < w; i++) begin
         off = int'(s.t) - i;
         if (s.act && off >= 0 && off < w) r[8*i +: 8] = s.base + 8'(off);
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Advance one cycle, compare both instances against the model, return at negedge+1.
   task automatic tick();
      @(negedge clk);
      chk("w4_en",    128'(if4.rd_en),    e_en(m4, 4));
      chk("w4_addr",  128'(if4.rd_addr),  e_addr(m4, 4));
      chk("w4_busy",  128'(if4.busy),     128'(m4.act));
      chk("w4_done",  128'(if4.done),     128'(m4.done));
      chk("w16_en",   128'(if16.rd_en),   e_en(m16, 16));
      chk("w16_addr", 128'(if16.rd_addr), e_addr(m16, 16));
      chk("w16_busy", 128'(if16.busy),    128'(m16.act));
      chk("w16_done", 128'(if16.done),    128'(m16.done));
      #1;
   endtask

   typedef struct {
      logic        start;
      logic [7:0]  base;
      logic [3:0]  en;
      logic [31:0] addr;
      logic        busy;
      logic        done;
   } vec_t;

   vec_t        vec[9];
   logic [7:0]  seen[4][$];
   logic [31:0] packed_seen;
   int          dn[$];
   int          busy_cnt, b15_first, b15_cnt, b15_err, done_at, abort_done;

   initial begin
      // Single W=4 wave at base 0x10, with a mid-wave start pulse and base change.
      vec[0] = '{1'b1, 8'h10, 4'b0001, 32'h0000_0010, 1'b1, 1'b0};
      vec[1] = '{1'b0, 8'h55, 4'b0011, 32'h0000_1011, 1'b1, 1'b0};
      vec[2] = '{1'b1, 8'h77, 4'b0111, 32'h0010_1112, 1'b1, 1'b0};
      vec[3] = '{1'b0, 8'h77, 4'b1111, 32'h1011_1213, 1'b1, 1'b0};
      vec[4] = '{1'b0, 8'h00, 4'b1110, 32'h1112_1300, 1'b1, 1'b0};
      vec[5] = '{1'b0, 8'h00, 4'b1100, 32'h1213_0000, 1'b1, 1'b0};
      vec[6] = '{1'b0, 8'h00, 4'b1000, 32'h1300_0000, 1'b1, 1'b0};
      vec[7] = '{1'b0, 8'h00, 4'b0000, 32'h0000_0000, 1'b0, 1'b1};
      vec[8] = '{1'b0, 8'h00, 4'b0000, 32'h0000_0000, 1'b0, 1'b0};

      n_checks = 0;
      n_fail   = 0;
      rst4_n   = 1'b1;
      rst16_n  = 1'b1;
      if4.start = 1'b0;  if4.base_addr = 8'h00;
      if16.start = 1'b0; if16.base_addr = 8'h00;
      #1;
      rst4_n  = 1'b0;
      rst16_n = 1'b0;

      // Reset held, with start requested: nothing may happen.
      if4.start = 1'b1;
      repeat (4) tick();
      chk("rst_en4",   128'(if4.rd_en),   128'(0));
      chk("rst_addr4", 128'(if4.rd_addr), 128'(0));
      chk("rst_busy4", 128'(if4.busy),    128'(0));
      chk("rst_done4", 128'(if4.done),    128'(0));
      if4.start = 1'b0;
      rst4_n  = 1'b1;
      rst16_n = 1'b1;
      repeat (3) tick();
      chk("idle_busy4", 128'(if4.busy),  128'(0));
      chk("idle_en4",   128'(if4.rd_en), 128'(0));

      for (int r = 0; r < 9; r++) begin
         if4.start     = vec[r].start;
         if4.base_addr = vec[r].base;
         tick();
         chk($sformatf("vec%0d_en", r),   128'(if4.rd_en),   128'(vec[r].en));
         chk($sformatf("vec%0d_addr", r), 128'(if4.rd_addr), 128'(vec[r].addr));
         chk($sformatf("vec%0d_busy", r), 128'(if4.busy),    128'(vec[r].busy));
         chk($sformatf("vec%0d_done", r), 128'(if4.done),    128'(vec[r].done));
      end

      // Address wrap: every bank must see FE, FF, 00, 01 in order.
      if4.start     = 1'b1;
      if4.base_addr = 8'hFE;
      for (int c = 0; c < 8; c++) begin
         tick();
         if4.start = 1'b0;
         for (int b = 0; b < 4; b++) begin
            if (if4.rd_en[b]) seen[b].push_back(if4.rd_addr[8*b +: 8]);
         end
      end
      for (int b = 0; b < 4; b++) begin
         packed_seen = '0;
         foreach (seen[b][j]) packed_seen = {packed_seen[23:0], seen[b][j]};
         chk($sformatf("wrap_len_b%0d", b), 128'(seen[b].size()), 128'(4));
         chk($sformatf("wrap_seq_b%0d", b), 128'(packed_seen), 128'(32'hFEFF_0001));
      end
      tick();

      // Start held high: back-to-back waves separated by exactly one done cycle.
      if4.start     = 1'b1;
      if4.base_addr = 8'h20;
      for (int c = 1; c <= 30; c++) begin
         tick();
         if (if4.done) dn.push_back(c);
      end
      if4.start = 1'b0;
      chk("held_done_count", 128'(dn.size()), 128'(3));
      if (dn.size() == 3) begin
         chk("held_first_done", 128'(dn[0]), 128'(8));
         chk("held_gap0", 128'(dn[1] - dn[0]), 128'(8));
         chk("held_gap1", 128'(dn[2] - dn[1]), 128'(8));
      end
      repeat (10) tick();

      // W=16: abort mid-wave at t=9 with an asynchronous reset between edges.
      if16.start     = 1'b1;
      if16.base_addr = 8'h40;
      tick();
      if16.start = 1'b0;
      repeat (9) tick();
      chk("pre_abort_en", 128'(if16.rd_en), 128'(16'h03FF));
      #2;
      rst16_n = 1'b0;
      #1;
      chk("abort_en",   128'(if16.rd_en),   128'(0));
      chk("abort_addr", 128'(if16.rd_addr), 128'(0));
      chk("abort_busy", 128'(if16.busy),    128'(0));
      repeat (3) tick();
      rst16_n    = 1'b1;
      abort_done = 0;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (if16.done) abort_done++;
      end
      chk("abort_no_done", 128'(abort_done), 128'(0));

      // Fresh full-width wave at base 0.
      if16.start     = 1'b1;
      if16.base_addr = 8'h00;
      busy_cnt  = 0;
      b15_first = -1;
      b15_cnt   = 0;
      b15_err   = 0;
      done_at   = -1;
      for (int n = 1; n <= 40; n++) begin
         tick();
         if16.start = 1'b0;
         if (if16.busy) busy_cnt++;
         if (if16.done && done_at < 0) done_at = n;
         if (if16.rd_en[15]) begin
            if (b15_first < 0) b15_first = n;
            if (if16.rd_addr[127:120] != 8'(n - 16)) b15_err++;
            b15_cnt++;
         end
      end
      chk("w16_busy_cycles", 128'(busy_cnt),  128'(31));
      chk("w16_done_cycle",  128'(done_at),   128'(32));
      chk("w16_b15_first",   128'(b15_first), 128'(16));
      chk("w16_b15_count",   128'(b15_cnt),   128'(16));
      chk("w16_b15_addr",    128'(b15_err),   128'(0));

      // Random traffic on both instances, including occasional asynchronous resets.
      for (int c = 0; c < 400; c++) begin
         if4.start      = ($urandom_range(0, 3) == 0);
         if4.base_addr  = 8'($urandom);
         if16.start     = ($urandom_range(0, 3) == 0);
         if16.base_addr = 8'($urandom);
         rst4_n         = ($urandom_range(0, 99) != 0);
         rst16_n        = ($urandom_range(0, 99) != 0);
         tick();
      end
      rst4_n  = 1'b1;
      rst16_n = 1'b1;
      if4.start  = 1'b0;
      if16.start = 1'b0;
      repeat (35) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/rd_control.md
# rd_control

Read-side sequencer for the systolic array's per-row memory banks (memArr). On a start pulse it produces a diagonally skewed read wave: bank 0 begins reading one cycle before bank 1, bank 1 one cycle before bank 2, and so on. Each bank reads `width_height` consecutive words from a common base offset, so operands enter the array already staggered. It issues the enable and address pattern from the opposite end of memArr to the write sequencer, and signals busy and completion to the top-level controller.

## Interface
- `width_height`, 16, number of banks / array rows; also the number of words each bank reads per wave.
- `data_width` (localparam), `8*width_height`, packed address bus width (8 bits per bank).

- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset; 0 forces reset state immediately, independent of `clk`.
- `start`  in  1  request for one read wave; sampled on the rising edge.
- `base_addr`  in  8  starting word offset, common to all banks; captured on the accepting edge.
- `rd_en`  out  `width_height`  per-bank read enable; bit i drives bank i.
- `rd_addr`  out  `data_width`  packed per-bank addresses; bank i uses bits [8i+7:8i].
- `busy`  out  1  high while a wave is in progress.
- `done`  out  1  one-cycle pulse after the last read of a wave.

## Operation
- State machine with two states: IDLE and RUN.
- Cycle counter `t`: `$clog2(2*width_height)` bits wide.
- Base register: 8 bits.
- IDLE:
  - `start`=1 on an edge latches `base_addr`, clears `t`, and enters RUN.
  - `start`=0 holds IDLE.
- RUN, in cycle `t` (t = 0 … 2·width_height−2):
  - `rd_en[i]`=1 iff i ≤ t ≤ i+width_height−1.
  - Bank i address = base + (t−i) mod 256 while enabled; 0 while disabled.
- Last RUN cycle (t = 2·width_height−2): the next edge returns to IDLE and raises `done` for exactly one cycle.
- `start` while in RUN is ignored. No queuing, no restart.
- `start` in the `done` cycle is accepted, because that cycle is IDLE. Waves can therefore run back-to-back with one idle cycle between them.
- `base_addr` changes after acceptance have no effect on the current wave.
- Address arithmetic is 8-bit and wraps modulo 256 (base 0xFE → 0xFE, 0xFF, 0x00, …).
- Reset (`reset`=0), at any time including mid-wave:
  - Returns to IDLE.
  - `rd_en`=0, `rd_addr`=0, `busy`=0, `done`=0, base=0, `t`=0.
  - The aborted wave does not resume and produces no `done`.

## Timing
- All outputs are registered.
- Reset values: every output 0.
- Latency: `start` sampled at edge k → `rd_en`=…0001 and bank-0 address = base, visible after edge k+1 (t=0).
- `busy`:
  - Rises at edge k+1.
  - Stays high for exactly 2·width_height−1 cycles, coinciding with a nonzero `rd_en`.
- `done`: high for one cycle starting at edge k+2·width_height, with `busy`=0 and `rd_en`=0 in that cycle.
- `rd_en` popcount follows 1, 2, … width_height−1, width_height, width_height−1, … 1 across the wave.
- Each bank asserts enable for exactly width_height consecutive cycles. Its address increments by 1 each cycle, starting at base.
- A deasserted bank address must read 0, never a stale value.

## Test plan
1. Reset behaviour (W=4): hold `reset`=0 for several cycles, then release → all outputs 0; no activity without `start`.
2. Single wave (W=4, base=0x10): pulse `start` at edge k.
   - `rd_en` = 0001, 0011, 0111, 1111, 1110, 1100, 1000 on cycles k+1 … k+7.
   - Bank 0 reads 0x10–0x13 on k+1 … k+4.
   - Bank 3 reads 0x10–0x13 on k+4 … k+7.
   - `done` pulses at k+8.
3. Address wrap (W=4, base=0xFE): pulse `start` → every bank reads 0xFE, 0xFF, 0x00, 0x01 in order.
4. `start` handling (W=4):
   - Hold `start`=1 continuously → waves repeat with exactly one idle (`done`) cycle between them.
   - A `start` pulse mid-wave has no effect.
   - `base_addr` changed mid-wave has no effect.
5. Async reset mid-wave (W=16): assert `reset`=0 at t=9, between clock edges.
   - `rd_en`, `rd_addr` and `busy` go to 0 before the next edge.
   - No `done` is produced.
   - A fresh `start` after release produces a full 31-cycle wave.
6. Default width (W=16, base=0x00):
   - `busy` stays high for 31 cycles.
   - Bank 15 is enabled on t=15 … 30 with addresses 0x00–0x0F.
   - `done` pulses on the 32nd cycle after the accepting edge.
